pixel_frame_reader: RTL and testbench
=====================================

PIXEL_FRAME_READER -- requirements
Module: pixel_frame_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning pixel word width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 SHALL have parameter DEPTH, default 16, meaning FIFO depth in words, a power of 2 and at least 4.
REQ-004 SHALL have parameter LEN_W, default 24, meaning word-count width.
REQ-005 SHALL have ports `clk_clk` (in, 1, sole clock) and `reset_reset_n` (in, 1, asynchronous active-low reset); there is one clock, and reset is asynchronous and active-low.
REQ-006 SHALL have `start` (in, 1): one-cycle pulse that begins a frame; ignored unless in IDLE.
REQ-007 SHALL have `stop` (in, 1): one-cycle abort request.
REQ-008 SHALL have `continuous` (in, 1): restart the frame automatically after completion.
REQ-009 SHALL have `base_addr` (in, ADDR_W) and `num_words` (in, LEN_W), both sampled on an accepted start.
REQ-010 SHALL have master ports `avm_address` (out, ADDR_W), `avm_read` (out, 1), `avm_waitrequest` (in, 1), `avm_readdata` (in, DATA_W), `avm_readdatavalid` (in, 1).
REQ-011 SHALL have stream ports `out_valid` (out, 1), `out_data` (out, DATA_W), `out_ready` (in, 1).
REQ-012 SHALL have `busy` (out, 1, state not IDLE), `irq` (out, 1, sticky frame-done), and `irq_clear` (in, 1).

Function
REQ-013 SHALL implement states IDLE, FETCH, DRAIN, ABORT.
- IDLE -> FETCH on start with num_words != 0.
- FETCH -> DRAIN when all reads are issued.
- DRAIN -> IDLE, or -> FETCH in continuous mode, when the last word is accepted on the output.
- Any non-IDLE state -> ABORT on stop.
- ABORT -> IDLE when outstanding reads = 0.
REQ-014 SHALL treat start with num_words = 0 as a no-op: stay in IDLE, irq unchanged.
REQ-015 SHALL count a read as issued on a cycle where avm_read=1 and avm_waitrequest=0; while waitrequest=1, avm_read and avm_address SHALL be held stable.
REQ-016 SHALL assert avm_read only in FETCH, and only while (outstanding + FIFO occupancy) < DEPTH, so the FIFO can never overflow.
REQ-017 SHALL issue addresses base_addr, base_addr+DATA_W/8, ..., wrapping modulo 2^ADDR_W.
REQ-018 SHALL push every avm_readdatavalid word into the FIFO in arrival order; outstanding decrements on each readdatavalid.
REQ-019 SHALL present the FIFO head on out_data with out_valid = FIFO not empty, except in ABORT.
- A word transfers when out_valid and out_ready are both 1.
- Once out_valid is 1, out_valid and out_data SHALL hold until the transfer.
REQ-020 SHALL have a latency of 2 cycles minimum from readdatavalid to out_valid.
REQ-021 SHALL sustain 1 word/cycle when waitrequest=0 and out_ready=1.
REQ-022 SHALL handle a simultaneous FIFO push and pop with occupancy unchanged, including when the FIFO is full and when it is empty (an empty FIFO with a push is not bypassed).
REQ-023 SHALL set irq on the cycle after the last word of a frame transfers; irq SHALL stay 1 until irq_clear.
REQ-024 SHALL let a set win over irq_clear when both occur in the same cycle.
REQ-025 SHALL, in continuous mode, re-issue from the original sampled base_addr with no idle cycle, and SHALL set irq per frame.
REQ-026 SHALL, in ABORT, issue no reads, drop readdatavalid data, flush the FIFO, and hold out_valid at 0; irq SHALL NOT set.
REQ-027 SHALL give stop priority over start and over frame completion in the same cycle.
REQ-028 SHALL ignore start while busy.

Reset
REQ-029 SHALL, on reset_reset_n=0, immediately force state IDLE, avm_read=0, avm_address=0, out_valid=0, out_data=0, irq=0, busy=0, FIFO empty, and all counters 0.
REQ-030 SHALL release reset synchronously internally; the first start is accepted 1 cycle after deassertion.
REQ-031 SHALL treat reset mid-frame as discarding all state; readdatavalid arriving after reset in IDLE SHALL be ignored.

Verification
REQ-032 Single frame: base 0x1000, num_words 8, waitrequest=0, out_ready=1 -> addresses 0x1000..0x101C step 4, 8 words out in order, irq=1 after the last word, busy=0.
REQ-033 Backpressure: out_ready=0 for 40 cycles, DEPTH=16, num_words 64 -> no more than 16 words outstanding plus buffered, no data loss, all 64 words delivered in order.
REQ-034 Waitrequest: random waitrequest plus readdatavalid delay of 1-5 cycles -> avm_address stable while stalled, exactly num_words reads issued.
REQ-035 Continuous: num_words 4, continuous=1, 3 frames -> 12 words, addresses repeat the 0x1000 base, irq re-asserts after each irq_clear.
REQ-036 Abort: stop after 5 of 32 words with 3 reads outstanding -> ABORT until 3 readdatavalid arrive, out_valid=0, IDLE, irq=0.
REQ-037 Edges: num_words 0 -> no reads; address 0xFFFFFFFC with num_words 2 -> second address is 0x00000000; reset asserted mid-frame -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/pixel_frame_reader.sv
// Frame reader: fetches num_words pixel words over an Avalon-MM read master and
// streams them out through a credit-limited FIFO, with continuous and abort modes.
module pixel_frame_reader #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 16,
   parameter int LEN_W  = 24
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic              start,
   input  logic              stop,
   input  logic              continuous,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  num_words,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   input  logic              avm_waitrequest,
   input  logic [DATA_W-1:0] avm_readdata,
   input  logic              avm_readdatavalid,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              busy,
   output logic              irq,
   input  logic              irq_clear
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(DATA_W / 8);
   localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, ABORT} state_t;

   logic              rst_sync_q;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  issue_rem_q, issue_rem_d;
   logic [LEN_W-1:0]  out_rem_q, out_rem_d;
   logic [CNT_W-1:0]  outst_q, outst_d;
   logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic              rdv_q, rdv_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              irq_q, irq_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic credit_ok, issue, pop, push, frame_done, accept, restart, valid_int;

   // Reset asserts immediately but releases on a clock edge.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) rst_sync_q <= 1'b0;
      else                rst_sync_q <= 1'b1;
   end

   always_ff @(posedge clk_clk or negedge rst_sync_q) begin
      if (!rst_sync_q) state_q <= IDLE;
      else             state_q <= state_d;
   end

   always_comb begin
      credit_ok  = ({1'b0, outst_q} + {1'b0, fifo_cnt_q}) < DEPTH_C;
      issue      = avm_read && !avm_waitrequest;
      pop        = valid_int && out_ready;
      push       = rdv_q && (state_q == FETCH || state_q == DRAIN);
      frame_done = (state_q == DRAIN) && pop && (out_rem_q == LEN_W'(1));
      accept     = (state_q == IDLE) && start && (num_words != '0);
      restart    = frame_done && continuous && !stop;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (accept) state_d = FETCH;
         FETCH: begin
            if (stop)                                        state_d = ABORT;
            else if (issue && issue_rem_q == LEN_W'(1))      state_d = DRAIN;
         end
         DRAIN: begin
            if (stop)            state_d = ABORT;
            else if (frame_done) state_d = continuous ? FETCH : IDLE;
         end
         ABORT: if (outst_q == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      avm_read    = (state_q == FETCH) && (issue_rem_q != '0) && credit_ok;
      avm_address = addr_q;
      valid_int   = (state_q != ABORT) && (fifo_cnt_q != '0);
      out_valid   = valid_int;
      out_data    = valid_int ? mem_q[rd_ptr_q] : '0;
      busy        = (state_q != IDLE);
      irq         = irq_q;
   end

   // Outstanding counts every read until its word leaves the input stage, so
   // outstanding + occupancy never exceeds DEPTH.
   always_comb begin
      addr_d      = addr_q;
      base_d      = base_q;
      len_d       = len_q;
      issue_rem_d = issue_rem_q;
      out_rem_d   = out_rem_q;
      rdv_d       = avm_readdatavalid;
      rdata_d     = avm_readdata;
      outst_d     = outst_q + CNT_W'(issue) - CNT_W'(rdv_q && (outst_q != '0));
      fifo_cnt_d  = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d    = wr_ptr_q + PTR_W'(push);
      rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
      if (accept) begin
         base_d      = base_addr;
         len_d       = num_words;
         addr_d      = base_addr;
         issue_rem_d = num_words;
         out_rem_d   = num_words;
      end else if (restart) begin
         addr_d      = base_q;
         issue_rem_d = len_q;
         out_rem_d   = len_q;
      end else begin
         if (issue) begin
            addr_d      = addr_q + STEP;
            issue_rem_d = issue_rem_q - LEN_W'(1);
         end
         if (pop) out_rem_d = out_rem_q - LEN_W'(1);
      end
      if (state_q == ABORT) begin
         fifo_cnt_d = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
      end
      if (frame_done && !stop) irq_d = 1'b1;
      else if (irq_clear)      irq_d = 1'b0;
      else                     irq_d = irq_q;
   end

   always_ff @(posedge clk_clk or negedge rst_sync_q) begin
      if (!rst_sync_q) begin
         addr_q      <= '0;
         base_q      <= '0;
         len_q       <= '0;
         issue_rem_q <= '0;
         out_rem_q   <= '0;
         outst_q     <= '0;
         fifo_cnt_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         rdv_q       <= 1'b0;
         rdata_q     <= '0;
         irq_q       <= 1'b0;
      end else begin
         addr_q      <= addr_d;
         base_q      <= base_d;
         len_q       <= len_d;
         issue_rem_q <= issue_rem_d;
         out_rem_q   <= out_rem_d;
         outst_q     <= outst_d;
         fifo_cnt_q  <= fifo_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         rdv_q       <= rdv_d;
         rdata_q     <= rdata_d;
         irq_q       <= irq_d;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (push) mem_q[wr_ptr_q] <= rdata_q;
   end

endmodule

// File: tb/tb_pixel_frame_reader.sv
// Randomized bench for pixel_frame_reader: a memory slave with random stalls and
// latency, a random-ready sink, and an address/data reference model.
module tb_pixel_frame_reader;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int DEPTH  = 16;
   localparam int LEN_W  = 24;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0, stop = 1'b0, continuous = 1'b0, irq_clear = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [LEN_W-1:0]  num_words = '0;
   logic [ADDR_W-1:0] avm_address;
   logic              avm_read;
   logic              avm_waitrequest = 1'b0;
   logic [DATA_W-1:0] avm_readdata = '0;
   logic              avm_readdatavalid = 1'b0;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready = 1'b0;
   logic              busy, irq;

   pixel_frame_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
      .clk_clk(clk), .reset_reset_n(rst_n), .start(start), .stop(stop),
      .continuous(continuous), .base_addr(base_addr), .num_words(num_words),
      .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
      .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .busy(busy), .irq(irq), .irq_clear(irq_clear)
   );

   always #5 clk = ~clk;

   int chk_cnt = 0, pass_cnt = 0;
   logic [31:0] issued[$], received[$], pend_data[$];
   int          pend_due[$], recv_cyc[$];
   int cyc = 0, last_due = 0, first_rdv_cyc = -1, max_inflight = 0;
   int hold_err = 0, stall_err = 0;
   bit protocol_chk = 1'b1;
   int wr_mode = 0, dmin = 1, dmax = 1, ready_mode = 0;
   logic prev_valid = 1'b0, prev_ready = 1'b0, prev_read = 1'b0, prev_wr = 1'b0;
   logic [31:0] prev_data = '0, prev_addr = '0;

   // Contents of the simulated frame buffer at a given byte address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
   endfunction

   function automatic logic [31:0] exp_addr(input logic [31:0] b, input int i);
      return b + 32'(i * 4);
   endfunction

   // Slave and sink: decisions made on the falling edge for the next rising edge.
   initial begin
      forever begin
         int  due;
         logic wr, rdy;
         @(negedge clk);
         cyc++;
         if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = pend_data.pop_front();
            void'(pend_due.pop_front());
            if (first_rdv_cyc < 0) first_rdv_cyc = cyc;
         end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = $urandom;
         end
         wr = (wr_mode != 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
         avm_waitrequest = wr;
         if (protocol_chk && prev_read && prev_wr && (avm_read !== 1'b1 || avm_address !== prev_addr))
            stall_err++;
         if (avm_read === 1'b1 && !wr) begin
            issued.push_back(avm_address);
            due = cyc + int'($urandom_range(dmin, dmax));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_due.push_back(due);
            pend_data.push_back(mem_word(avm_address));
         end
         prev_read = avm_read;
         prev_wr   = wr;
         prev_addr = avm_address;
         case (ready_mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'b0;
            default: rdy = ($urandom_range(0, 1) == 1);
         endcase
         out_ready = rdy;
         if (protocol_chk && prev_valid && !prev_ready && (out_valid !== 1'b1 || out_data !== prev_data))
            hold_err++;
         if (out_valid === 1'b1 && rdy) begin
            received.push_back(out_data);
            recv_cyc.push_back(cyc);
         end
         prev_valid = out_valid;
         prev_ready = rdy;
         prev_data  = out_data;
         if (issued.size() - received.size() > max_inflight)
            max_inflight = issued.size() - received.size();
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected bench to finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic drain_slave;
      int k = 0;
      while ((pend_due.size() > 0 || busy === 1'b1) && k < 200) begin
         tick();
         k++;
      end
   endtask

   task automatic clear_bench;
      issued.delete();
      received.delete();
      recv_cyc.delete();
      first_rdv_cyc = -1;
      max_inflight  = 0;
      hold_err      = 0;
      stall_err     = 0;
   endtask

   task automatic start_frame(input logic [31:0] b, input int n);
      base_addr = b;
      num_words = LEN_W'(n);
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_recv(input int n, input int bound, output bit ok);
      int k = 0;
      while (received.size() < n && k < bound) begin
         tick();
         k++;
      end
      ok = (received.size() >= n);
   endtask

   task automatic pulse_irq_clear;
      irq_clear = 1'b1;
      tick();
      irq_clear = 1'b0;
   endtask

   task automatic check_data(input string name, input logic [31:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         logic [31:0] got;
         got = (i < received.size()) ? received[i] : 32'hxxxx_xxxx;
         chk_cnt++;
         if (got !== mem_word(exp_addr(b, i)))
            $display("[TB] FAIL %s_data[%0d]: got %h expected %h", name, i, got, mem_word(exp_addr(b, i)));
         else pass_cnt++;
      end
   endtask

   task automatic test_reset;
      bit ok;
      rst_n = 1'b0;
      tick();
      tick();
      chk_cnt++; if (avm_read !== 1'b0) $display("[TB] FAIL reset_avm_read: got %b expected 0", avm_read); else pass_cnt++;
      chk_cnt++; if (avm_address !== '0) $display("[TB] FAIL reset_avm_address: got %h expected 0", avm_address); else pass_cnt++;
      chk_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); else pass_cnt++;
      chk_cnt++; if (out_data !== '0) $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); else pass_cnt++;
      chk_cnt++; if (irq !== 1'b0) $display("[TB] FAIL reset_irq: got %b expected 0", irq); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
      rst_n = 1'b1;
      tick();
      clear_bench();
      start_frame(32'h0000_0040, 2);
      chk_cnt++; if (busy !== 1'b1) $display("[TB] FAIL reset_first_start: busy got %b expected 1", busy); else pass_cnt++;
      wait_recv(2, 100, ok);
      tick();
      chk_cnt++; if (!ok) $display("[TB] FAIL reset_frame_timeout: got %0d words expected 2", received.size()); else pass_cnt++;
      check_data("reset_frame", 32'h0000_0040, 2);
      chk_cnt++; if (irq !== 1'b1) $display("[TB] FAIL reset_frame_irq: got %b expected 1", irq); else pass_cnt++;
      pulse_irq_clear();
      chk_cnt++; if (irq !== 1'b0) $display("[TB] FAIL irq_clear: got %b expected 0", irq); else pass_cnt++;
   endtask

   task automatic test_single_frame;
      bit ok;
      drain_slave();
      clear_bench();
      start_frame(32'h0000_1000, 8);
      wait_recv(8, 200, ok);
      irq_clear = 1'b1;
      tick();
      irq_clear = 1'b0;
      chk_cnt++; if (!ok) $display("[TB] FAIL single_timeout: got %0d words expected 8", received.size()); else pass_cnt++;
      chk_cnt++; if (irq !== 1'b1) $display("[TB] FAIL single_irq_set_beats_clear: got %b expected 1", irq); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("[TB] FAIL single_busy: got %b expected 0", busy); else pass_cnt++;
      chk_cnt++; if (issued.size() !== 8) $display("[TB] FAIL single_read_count: got %0d expected 8", issued.size()); else pass_cnt++;
      for (int i = 0; i < 8; i++) begin
         logic [31:0] a;
         a = (i < issued.size()) ? issued[i] : 32'hxxxx_xxxx;
         chk_cnt++;
         if (a !== exp_addr(32'h0000_1000, i)) $display("[TB] FAIL single_addr[%0d]: got %h expected %h", i, a, exp_addr(32'h0000_1000, i));
         else pass_cnt++;
      end
      check_data("single", 32'h0000_1000, 8);
      chk_cnt++;
      if (recv_cyc.size() < 8 || recv_cyc[7] - recv_cyc[0] != 7)
         $display("[TB] FAIL single_throughput: got span %0d expected 7", (recv_cyc.size() >= 8) ? recv_cyc[7] - recv_cyc[0] : -1);
      else pass_cnt++;
      chk_cnt++;
      if (recv_cyc.size() < 1 || recv_cyc[0] - first_rdv_cyc < 2)
         $display("[TB] FAIL single_latency: got %0d expected >= 2", (recv_cyc.size() > 0) ? recv_cyc[0] - first_rdv_cyc : -1);
      else pass_cnt++;
      pulse_irq_clear();
      chk_cnt++; if (irq !== 1'b0) $display("[TB] FAIL single_irq_clear: got %b expected 0", irq); else pass_cnt++;
   endtask

   task automatic test_backpressure;
      bit ok;
      logic [31:0] b;
      drain_slave();
      clear_bench();
      b = $urandom & 32'hFFFF_FFFC;
      ready_mode = 1;
      start_frame(b, 64);
      repeat (40) tick();
      chk_cnt++; if (issued.size() !== DEPTH) $display("[TB] FAIL bp_reads_while_blocked: got %0d expected %0d", issued.size(), DEPTH); else pass_cnt++;
      chk_cnt++; if (received.size() !== 0) $display("[TB] FAIL bp_words_while_blocked: got %0d expected 0", received.size()); else pass_cnt++;
      ready_mode = 2;
      wait_recv(64, 3000, ok);
      tick();
      chk_cnt++; if (!ok) $display("[TB] FAIL bp_timeout: got %0d words expected 64", received.size()); else pass_cnt++;
      check_data("bp", b, 64);
      chk_cnt++; if (issued.size() !== 64) $display("[TB] FAIL bp_read_count: got %0d expected 64", issued.size()); else pass_cnt++;
      chk_cnt++; if (max_inflight > DEPTH) $display("[TB] FAIL bp_inflight: got %0d expected <= %0d", max_inflight, DEPTH); else pass_cnt++;
      chk_cnt++; if (hold_err !== 0) $display("[TB] FAIL bp_out_hold: got %0d violations expected 0", hold_err); else pass_cnt++;
      chk_cnt++; if (irq !== 1'b1) $display("[TB] FAIL bp_irq: got %b expected 1", irq); else pass_cnt++;
      ready_mode = 0;
      pulse_irq_clear();
   endtask

   task automatic test_waitrequest;
      bit ok;
      int n;
      logic [31:0] b;
      drain_slave();
      clear_bench();
      n = $urandom_range(20, 40);
      b = $urandom & 32'hFFFF_FFFC;
      wr_mode = 1; dmin = 1; dmax = 5; ready_mode = 2;
      start_frame(b, n);
      wait_recv(n, 3000, ok);
      repeat (6) tick();
      chk_cnt++; if (!ok) $display("[TB] FAIL wr_timeout: got %0d words expected %0d", received.size(), n); else pass_cnt++;
      chk_cnt++; if (issued.size() !== n) $display("[TB] FAIL wr_read_count: got %0d expected %0d", issued.size(), n); else pass_cnt++;
      chk_cnt++; if (stall_err !== 0) $display("[TB] FAIL wr_addr_stable: got %0d violations expected 0", stall_err); else pass_cnt++;
      chk_cnt++; if (hold_err !== 0) $display("[TB] FAIL wr_out_hold: got %0d violations expected 0", hold_err); else pass_cnt++;
      for (int i = 0; i < n; i++) begin
         logic [31:0] a;
         a = (i < issued.size()) ? issued[i] : 32'hxxxx_xxxx;
         chk_cnt++;
         if (a !== exp_addr(b, i)) $display("[TB] FAIL wr_addr[%0d]: got %h expected %h", i, a, exp_addr(b, i));
         else pass_cnt++;
      end
      check_data("wr", b, n);
      chk_cnt++; if (irq !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL wr_done: got irq=%b busy=%b expected irq=1 busy=0", irq, busy); else pass_cnt++;
      wr_mode = 0; dmin = 1; dmax = 1; ready_mode = 0;
      pulse_irq_clear();
   endtask

   task automatic test_continuous;
      bit ok;
      drain_slave();
      clear_bench();
      continuous = 1'b1;
      start_frame(32'h0000_1000, 4);
      wait_recv(4, 200, ok);
      tick();
      chk_cnt++; if (!ok || irq !== 1'b1) $display("[TB] FAIL cont_frame1: got words=%0d irq=%b expected 4 and 1", received.size(), irq); else pass_cnt++;
      pulse_irq_clear();
      chk_cnt++; if (irq !== 1'b0) $display("[TB] FAIL cont_clear1: got %b expected 0", irq); else pass_cnt++;
      wait_recv(8, 200, ok);
      tick();
      chk_cnt++; if (!ok || irq !== 1'b1) $display("[TB] FAIL cont_frame2: got words=%0d irq=%b expected 8 and 1", received.size(), irq); else pass_cnt++;
      continuous = 1'b0;
      pulse_irq_clear();
      chk_cnt++; if (irq !== 1'b0) $display("[TB] FAIL cont_clear2: got %b expected 0", irq); else pass_cnt++;
      wait_recv(12, 200, ok);
      tick();
      chk_cnt++; if (!ok || irq !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL cont_frame3: got words=%0d irq=%b busy=%b expected 12, 1, 0", received.size(), irq, busy); else pass_cnt++;
      chk_cnt++; if (issued.size() !== 12) $display("[TB] FAIL cont_read_count: got %0d expected 12", issued.size()); else pass_cnt++;
      for (int i = 0; i < 12; i++) begin
         logic [31:0] a, d;
         a = (i < issued.size()) ? issued[i] : 32'hxxxx_xxxx;
         d = (i < received.size()) ? received[i] : 32'hxxxx_xxxx;
         chk_cnt++;
         if (a !== exp_addr(32'h0000_1000, i % 4) || d !== mem_word(exp_addr(32'h0000_1000, i % 4)))
            $display("[TB] FAIL cont_word[%0d]: got addr %h data %h expected %h %h", i, a, d,
                     exp_addr(32'h0000_1000, i % 4), mem_word(exp_addr(32'h0000_1000, i % 4)));
         else pass_cnt++;
      end
      pulse_irq_clear();
   endtask

   task automatic test_abort;
      bit ok;
      int n_iss, n_rx, k, ov_err, rd_err;
      drain_slave();
      clear_bench();
      dmin = 3; dmax = 5;
      start_frame(32'h0000_2000, 32);
      wait_recv(5, 200, ok);
      protocol_chk = 1'b0;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      n_iss = issued.size();
      n_rx  = received.size();
      chk_cnt++; if (busy !== 1'b1) $display("[TB] FAIL abort_waits: busy got %b expected 1", busy); else pass_cnt++;
      k = 0; ov_err = 0; rd_err = 0;
      while (busy === 1'b1 && k < 100) begin
         if (out_valid !== 1'b0) ov_err++;
         if (avm_read !== 1'b0) rd_err++;
         tick();
         k++;
      end
      chk_cnt++; if (busy !== 1'b0) $display("[TB] FAIL abort_idle: busy got %b expected 0", busy); else pass_cnt++;
      chk_cnt++; if (pend_due.size() !== 0) $display("[TB] FAIL abort_outstanding: got %0d pending at idle expected 0", pend_due.size()); else pass_cnt++;
      chk_cnt++; if (ov_err !== 0) $display("[TB] FAIL abort_out_valid: got %0d cycles high expected 0", ov_err); else pass_cnt++;
      chk_cnt++; if (rd_err !== 0 || issued.size() !== n_iss) $display("[TB] FAIL abort_no_reads: got %0d reads expected %0d", issued.size(), n_iss); else pass_cnt++;
      chk_cnt++; if (received.size() !== n_rx) $display("[TB] FAIL abort_no_words: got %0d expected %0d", received.size(), n_rx); else pass_cnt++;
      chk_cnt++; if (irq !== 1'b0 || out_valid !== 1'b0) $display("[TB] FAIL abort_irq: got irq=%b out_valid=%b expected 0 0", irq, out_valid); else pass_cnt++;
      check_data("abort", 32'h0000_2000, n_rx);
      protocol_chk = 1'b1;
      dmin = 1; dmax = 1;
   endtask

   task automatic test_wrap;
      bit ok;
      drain_slave();
      clear_bench();
      start_frame(32'hFFFF_FFFC, 2);
      wait_recv(2, 100, ok);
      tick();
      chk_cnt++; if (!ok) $display("[TB] FAIL wrap_timeout: got %0d words expected 2", received.size()); else pass_cnt++;
      chk_cnt++; if (issued.size() !== 2 || issued[0] !== 32'hFFFF_FFFC || issued[1] !== 32'h0)
         $display("[TB] FAIL wrap_addr: got %0d reads, second %h expected 2 reads, second 00000000", issued.size(), (issued.size() > 1) ? issued[1] : 32'hxxxx_xxxx);
      else pass_cnt++;
      check_data("wrap", 32'hFFFF_FFFC, 2);
      chk_cnt++; if (irq !== 1'b1) $display("[TB] FAIL wrap_irq: got %b expected 1", irq); else pass_cnt++;
   endtask

   task automatic test_zero_len;
      drain_slave();
      clear_bench();
      start_frame(32'h0000_3000, 0);
      repeat (5) tick();
      chk_cnt++; if (busy !== 1'b0) $display("[TB] FAIL zero_busy: got %b expected 0", busy); else pass_cnt++;
      chk_cnt++; if (issued.size() !== 0) $display("[TB] FAIL zero_reads: got %0d expected 0", issued.size()); else pass_cnt++;
      chk_cnt++; if (irq !== 1'b1) $display("[TB] FAIL zero_irq_unchanged: got %b expected 1", irq); else pass_cnt++;
   endtask

   task automatic test_reset_midframe;
      bit ok;
      int err;
      logic [31:0] b;
      drain_slave();
      clear_bench();
      dmin = 2; dmax = 5;
      start_frame(32'h0000_4000, 32);
      wait_recv(6, 200, ok);
      protocol_chk = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_cnt++;
      if ({avm_read, out_valid, busy, irq} !== 4'b0 || avm_address !== '0 || out_data !== '0)
         $display("[TB] FAIL midreset_outputs: got read=%b valid=%b busy=%b irq=%b addr=%h data=%h expected all 0",
                  avm_read, out_valid, busy, irq, avm_address, out_data);
      else pass_cnt++;
      tick();
      tick();
      rst_n = 1'b1;
      err = 0;
      repeat (24) begin
         tick();
         if (out_valid !== 1'b0 || busy !== 1'b0 || avm_read !== 1'b0) err++;
      end
      chk_cnt++; if (err !== 0) $display("[TB] FAIL midreset_stale_data: got %0d active cycles expected 0", err); else pass_cnt++;
      protocol_chk = 1'b1;
      dmin = 1; dmax = 1;
      drain_slave();
      clear_bench();
      b = $urandom & 32'hFFFF_FFFC;
      start_frame(b, 3);
      wait_recv(3, 100, ok);
      tick();
      chk_cnt++; if (!ok || irq !== 1'b1) $display("[TB] FAIL midreset_recover: got words=%0d irq=%b expected 3 and 1", received.size(), irq); else pass_cnt++;
      check_data("midreset", b, 3);
   endtask

   initial begin
      $display("[TB] pixel_frame_reader bench starting");
      test_reset();
      test_single_frame();
      test_backpressure();
      test_waitrequest();
      test_continuous();
      test_abort();
      test_wrap();
      test_zero_len();
      test_reset_midframe();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
